// File: rtl/spi_bank_loader_pkg.sv
// Shared definitions for the SPI bank loader: command codes, FSM states and
// the layout of a queued SDRAM write.
package spi_bank_loader_pkg;

    localparam logic [7:0] CMD_PING    = 8'h00;
    localparam logic [7:0] CMD_RUN     = 8'h02;
    localparam logic [7:0] CMD_KEY     = 8'h03;
    localparam logic [7:0] CMD_BANK    = 8'h04;
    localparam logic [7:0] CMD_STATUS  = 8'h05;
    localparam logic [7:0] CMD_HALT    = 8'h06;
    localparam logic [7:0] CMD_BANK_HI = 8'h07;

    localparam logic [7:0] RESP_OK_DEFAULT = 8'hA5;

    localparam int BANK_W   = 9;
    localparam int OFFSET_W = 14;
    localparam int ADDR_W   = BANK_W + OFFSET_W;

    typedef enum logic [2:0] {
        S_CMD,
        S_KEY_Y,
        S_KEY_X,
        S_BANK,
        S_DATA,
        S_STATUS,
        S_IGNORE
    } state_t;

    typedef struct packed {
        logic [BANK_W-1:0]   bank;
        logic [OFFSET_W-1:0] offset;
        logic [7:0]          data;
    } wr_entry_t;

    function automatic logic [7:0] status_byte(input logic ovf, input logic busy);
        return {6'b0, ovf, busy};
    endfunction

endpackage

// File: rtl/spi_bank_loader_if.sv
// SDRAM write-request bus between the loader (master) and the SDRAM
// controller (slave).
interface spi_bank_loader_if;
    import spi_bank_loader_pkg::*;

    logic              sdram_init_busy;
    logic              sdram_wr;
    logic              sdram_ack;
    logic [ADDR_W-1:0] sdram_address;
    logic [7:0]        sdram_wdata;

    modport master (
        input  sdram_init_busy,
        input  sdram_ack,
        output sdram_wr,
        output sdram_address,
        output sdram_wdata
    );

    modport slave (
        output sdram_init_busy,
        output sdram_ack,
        input  sdram_wr,
        input  sdram_address,
        input  sdram_wdata
    );

endinterface

// File: rtl/spi_bank_loader_fifo.sv
// Synchronous FIFO with a combinational head; DEPTH must be a power of two.
// A pop frees a slot for a push in the same cycle, so both are legal when full.
module spi_bank_loader_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/spi_bank_loader.sv
// SPI command decoder that loads key-matrix writes, CPU reset control and
// queued SDRAM bank writes. Define SPI_BANK_LOADER_OVERFLOW_EN for a sticky
// FIFO-overflow flag in the status byte.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   S_CMD    | waiting for the command byte of a frame
//   S_KEY_Y  | next byte is the key row
//   S_KEY_X  | next byte is the key column data, then strobe
//   S_BANK   | next byte is bank low (04) or bank_hi select (07)
//   S_DATA   | every byte is queued as an SDRAM write
//   S_STATUS | status already loaded; next byte is a dummy
//   S_IGNORE | discard bytes until the frame ends
module spi_bank_loader
    import spi_bank_loader_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] RESP_OK    = RESP_OK_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_active,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic [7:0]                tx_data,
    output logic                      key_we,
    output logic [3:0]                key_y,
    output logic [7:0]                key_x,
    output logic                      cpu_reset,
    spi_bank_loader_if.master         sdram
);

    state_t              state;
    logic                hi_sel;
    logic                bank_hi;
    logic [BANK_W-1:0]   bank;
    logic [OFFSET_W-1:0] offset;

    logic                byte_in;
    logic                data_push;
    logic                push_ok;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                busy;
    logic                ovf;
    wr_entry_t           push_entry;
    wr_entry_t           head;

    assign byte_in    = frame_active && rx_valid;
    assign data_push  = byte_in && (state == S_DATA);
    assign push_ok    = data_push && (!fifo_full || fifo_pop);
    assign push_entry = '{bank: bank, offset: offset, data: rx_data};

    // Head of the queue is the live request; ack retires it this cycle.
    assign sdram.sdram_wr      = !fifo_empty && !sdram.sdram_init_busy;
    assign sdram.sdram_address = fifo_empty ? '0 : {head.bank, head.offset};
    assign sdram.sdram_wdata   = fifo_empty ? '0 : head.data;
    assign fifo_pop            = sdram.sdram_wr && sdram.sdram_ack;

    assign busy = sdram.sdram_init_busy || !fifo_empty || sdram.sdram_wr;

    spi_bank_loader_fifo #(
        .WIDTH ($bits(wr_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef SPI_BANK_LOADER_OVERFLOW_EN
    logic drop;
    logic status_read;

    assign drop        = data_push && !push_ok;
    assign status_read = byte_in && (state == S_CMD) && (rx_data == CMD_STATUS);

    // The status read that reports the flag is also the one that clears it.
    always_ff @(posedge clk) begin
        if (reset)            ovf <= 1'b0;
        else if (drop)        ovf <= 1'b1;
        else if (status_read) ovf <= 1'b0;
    end
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_CMD;
            hi_sel    <= 1'b0;
            bank_hi   <= 1'b0;
            bank      <= '0;
            offset    <= '0;
            tx_data   <= RESP_OK;
            key_we    <= 1'b0;
            key_y     <= 4'h0;
            key_x     <= 8'hFF;
            cpu_reset <= 1'b1;
        end else begin
            key_we <= 1'b0;
            if (!frame_active) begin
                state <= S_CMD;
            end else if (rx_valid) begin
                tx_data <= RESP_OK;
                case (state)
                    S_CMD: begin
                        case (rx_data)
                            CMD_PING:    state <= S_CMD;
                            CMD_RUN:     cpu_reset <= 1'b0;
                            CMD_KEY:     state <= S_KEY_Y;
                            CMD_BANK: begin
                                hi_sel <= 1'b0;
                                state  <= S_BANK;
                            end
                            CMD_STATUS: begin
                                tx_data <= status_byte(ovf, busy);
                                state   <= S_STATUS;
                            end
                            CMD_HALT:    cpu_reset <= 1'b1;
                            CMD_BANK_HI: begin
                                hi_sel <= 1'b1;
                                state  <= S_BANK;
                            end
                            default:     state <= S_IGNORE;
                        endcase
                    end
                    S_KEY_Y: begin
                        key_y <= rx_data[3:0];
                        state <= S_KEY_X;
                    end
                    S_KEY_X: begin
                        key_x  <= rx_data;
                        key_we <= 1'b1;
                        state  <= S_IGNORE;
                    end
                    S_BANK: begin
                        if (hi_sel) begin
                            bank_hi <= rx_data[0];
                            state   <= S_IGNORE;
                        end else begin
                            bank   <= {bank_hi, rx_data};
                            offset <= '0;
                            state  <= S_DATA;
                        end
                    end
                    // Offset advances even when the byte is dropped.
                    S_DATA:   offset <= offset + OFFSET_W'(1);
                    S_STATUS: state <= S_IGNORE;
                    S_IGNORE: state <= S_IGNORE;
                    default:  state <= S_CMD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_bank_loader.sv
// Directed bench for spi_bank_loader with an SDRAM write scoreboard.
// Status expectations follow SPI_BANK_LOADER_OVERFLOW_EN.
module tb_spi_bank_loader;
    import spi_bank_loader_pkg::*;

`ifdef SPI_BANK_LOADER_OVERFLOW_EN
    localparam logic [7:0] EXP_OVF_STATUS = 8'h03;
`else
    localparam logic [7:0] EXP_OVF_STATUS = 8'h01;
`endif

    typedef struct {
        logic [22:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_active;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       key_we;
    logic [3:0] key_y;
    logic [7:0] key_x;
    logic       cpu_reset;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   key_we_cnt = 0;
    int   ack_mode = 0;
    exp_t exp_q[$];

    spi_bank_loader_if sdram_bus ();

    spi_bank_loader #(
        .FIFO_DEPTH (4),
        .RESP_OK    (8'hA5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_active (frame_active),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_data      (tx_data),
        .key_we       (key_we),
        .key_y        (key_y),
        .key_x        (key_x),
        .cpu_reset    (cpu_reset),
        .sdram        (sdram_bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [22:0] addr, input logic [7:0] data);
        exp_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic frame_begin();
        @(posedge clk); #1 frame_active = 1'b1;
    endtask

    task automatic frame_end();
        @(posedge clk); #1 frame_active = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    task automatic send_burst(input int n, input logic [8:0] bank);
        for (int i = 0; i < n; i++) begin
            expect_wr({bank, 14'(i)}, 8'(i * 7));
            @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'(i * 7);
        end
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    // SDRAM slave ack generator: 0 never, 1 every third cycle, 2 always.
    initial begin
        int ack_cyc = 0;
        sdram_bus.sdram_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            ack_cyc++;
            sdram_bus.sdram_ack = (ack_mode == 2) || (ack_mode == 1 && (ack_cyc % 3) == 0);
        end
    end

    always @(negedge clk) begin
        if (key_we) key_we_cnt++;
        if (!reset && sdram_bus.sdram_wr && sdram_bus.sdram_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", sdram_bus.sdram_wr, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", sdram_bus.sdram_address, e.addr);
                check("wr_data", sdram_bus.sdram_wdata, e.data);
            end
        end
        if (sdram_bus.sdram_init_busy) check("wr_during_init", sdram_bus.sdram_wr, 1'b0);
    end

    initial begin
        reset = 1'b1;
        frame_active = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        sdram_bus.sdram_init_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_tx_data", tx_data, 8'hA5);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_sdram_wr", sdram_bus.sdram_wr, 1'b0);
        check("rst_key_x", key_x, 8'hFF);
        check("rst_key_y", key_y, 4'h0);
        check("rst_key_we", key_we, 1'b0);
        check("rst_address", sdram_bus.sdram_address, 23'h0);

        // Ping frame
        frame_begin();
        send_byte(8'h00); check("ping_tx0", tx_data, 8'hA5);
        send_byte(8'h00); check("ping_tx1", tx_data, 8'hA5);
        frame_end();
        check("ping_cpu_reset", cpu_reset, 1'b1);
        check("ping_sdram_wr", sdram_bus.sdram_wr, 1'b0);

        // Status while SDRAM initialises, then idle
        sdram_bus.sdram_init_busy = 1'b1;
        frame_begin();
        send_byte(CMD_STATUS); check("status_init_busy", tx_data, 8'h01);
        send_byte(8'h00);      check("status_dummy_tx", tx_data, 8'hA5);
        frame_end();
        sdram_bus.sdram_init_busy = 1'b0;
        frame_begin();
        send_byte(CMD_STATUS); check("status_idle", tx_data, 8'h00);
        send_byte(8'h00);
        frame_end();

        // Key matrix write
        key_we_cnt = 0;
        frame_begin();
        send_byte(CMD_KEY);
        send_byte(8'h05);
        send_byte(8'h7F); check("key_tx", tx_data, 8'hA5);
        frame_end();
        check("key_we_pulses", key_we_cnt, 1);
        check("key_y", key_y, 4'h5);
        check("key_x", key_x, 8'h7F);

        // Unknown command ignores the rest of the frame
        frame_begin();
        send_byte(8'h09); send_byte(CMD_BANK); send_byte(8'h01);
        frame_end();
        frame_begin();
        send_byte(CMD_STATUS); check("unknown_no_push", tx_data, 8'h00);
        frame_end();

        // bank_hi then bank write; held off by init_busy, then ack every third cycle
        ack_mode = 1;
        sdram_bus.sdram_init_busy = 1'b1;
        frame_begin(); send_byte(CMD_BANK_HI); send_byte(8'h01); frame_end();
        expect_wr(23'h408000, 8'h11);
        expect_wr(23'h408001, 8'h22);
        expect_wr(23'h408002, 8'h33);
        frame_begin();
        send_byte(CMD_BANK); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        frame_end();
        check("init_busy_blocks_wr", sdram_bus.sdram_wr, 1'b0);
        sdram_bus.sdram_init_busy = 1'b0;
        wait_drain("drain_bank_hi", 200);

        // Overflow: ack held low, six bytes into a four-deep FIFO
        ack_mode = 0;
        frame_begin(); send_byte(CMD_BANK_HI); send_byte(8'h00); frame_end();
        for (int i = 1; i <= 4; i++) expect_wr({9'h010, 14'(i - 1)}, 8'(i));
        frame_begin();
        send_byte(CMD_BANK); send_byte(8'h10);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        frame_end();
        check("full_wr_held", sdram_bus.sdram_wr, 1'b1);
        check("full_head_addr", sdram_bus.sdram_address, 23'h040000);
        check("full_head_data", sdram_bus.sdram_wdata, 8'h01);
        frame_begin(); send_byte(CMD_STATUS); check("ovf_status", tx_data, EXP_OVF_STATUS); frame_end();
        frame_begin(); send_byte(CMD_STATUS); check("ovf_reread", tx_data, 8'h01); frame_end();
        ack_mode = 2;
        wait_drain("drain_overflow", 100);
        frame_begin(); send_byte(CMD_STATUS); check("status_after_drain", tx_data, 8'h00); frame_end();

        // Offset wrap: 2^14 + 1 back-to-back bytes, last lands at offset 0 of the same bank
        frame_begin();
        send_byte(CMD_BANK); send_byte(8'h03);
        send_burst(16385, 9'h003);
        frame_end();
        wait_drain("drain_wrap", 100);
        ack_mode = 0;

        // CPU reset control
        frame_begin(); send_byte(CMD_RUN);  frame_end(); check("cpu_run", cpu_reset, 1'b0);
        frame_begin(); send_byte(CMD_HALT); frame_end(); check("cpu_halt", cpu_reset, 1'b1);
        frame_begin(); send_byte(CMD_RUN);  frame_end(); check("cpu_run2", cpu_reset, 1'b0);

        // Reset in the middle of a data frame with requests pending
        frame_begin();
        send_byte(CMD_BANK); send_byte(8'h05); send_byte(8'hAA); send_byte(8'hBB);
        check("pre_reset_wr", sdram_bus.sdram_wr, 1'b1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("mid_reset_wr", sdram_bus.sdram_wr, 1'b0);
        check("mid_reset_addr", sdram_bus.sdram_address, 23'h0);
        check("mid_reset_cpu", cpu_reset, 1'b1);
        check("mid_reset_tx", tx_data, 8'hA5);
        send_byte(CMD_STATUS); check("mid_reset_state_cmd", tx_data, 8'h00);
        check("mid_reset_no_push", sdram_bus.sdram_wr, 1'b0);
        frame_end();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
